// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, state and strobe encodings for the CPU controller
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5,
        S6 = 3'd6,
        S7 = 3'd7
    } state_t;

    // Bit positions inside the decoded strobe vector
    localparam int STB_W        = 8;
    localparam int STB_LOAD_IR  = 7;
    localparam int STB_RD       = 6;
    localparam int STB_WR       = 5;
    localparam int STB_INC_PC   = 4;
    localparam int STB_LOAD_PC  = 3;
    localparam int STB_LOAD_ACC = 2;
    localparam int STB_DATACTL  = 1;
    localparam int STB_ALU_EN   = 0;

    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

endpackage

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational (state, opcode, zero) to strobe decode
module cpu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [2:0]       state,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic [STB_W-1:0] strobes
);

    logic aluop;
    logic sto;
    logic jmp;
    logic skip;

    always_comb begin
        aluop   = is_aluop(opcode);
        sto     = (opcode == OP_STO);
        jmp     = (opcode == OP_JMP);
        skip    = (opcode == OP_SKZ) && zero;
        strobes = '0;
        case (state_t'(state))
            S0: begin
                strobes[STB_RD]      = 1'b1;
                strobes[STB_LOAD_IR] = 1'b1;
            end
            S1: begin
                strobes[STB_RD]      = 1'b1;
                strobes[STB_LOAD_IR] = 1'b1;
                strobes[STB_INC_PC]  = 1'b1;
            end
            S2: begin
            end
            S3: begin
                strobes[STB_INC_PC] = 1'b1;
            end
            S4: begin
                strobes[STB_RD]      = aluop;
                strobes[STB_LOAD_PC] = jmp;
                strobes[STB_DATACTL] = sto;
            end
            S5: begin
                strobes[STB_RD]      = aluop;
                strobes[STB_ALU_EN]  = aluop;
                strobes[STB_LOAD_PC] = jmp;
                strobes[STB_DATACTL] = sto;
                strobes[STB_WR]      = sto;
                strobes[STB_INC_PC]  = skip;
            end
            S6: begin
                strobes[STB_RD]       = aluop;
                strobes[STB_LOAD_ACC] = aluop;
                strobes[STB_DATACTL]  = sto;
            end
            S7: begin
                // Second PC bump of a taken skip; the first came in S5
                strobes[STB_INC_PC] = skip;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-state instruction sequencer with halt and run-enable gating
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int OP_W        = 3,
    parameter bit HALT_STICKY = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [OP_W-1:0] opcode,
    input  logic            zero,
    output logic            load_ir,
    output logic            rd,
    output logic            wr,
    output logic            inc_pc,
    output logic            load_pc,
    output logic            load_acc,
    output logic            datactl_ena,
    output logic            alu_en,
    output logic            halt,
    output logic [2:0]      state
);

    state_t           state_q;
    logic             halted;
    logic             active;
    logic             gate;
    logic             halt_now;
    logic [STB_W-1:0] strobes;

    assign active   = en && !halted;
    assign halt_now = active && (state_q == S3) && (opcode == OP_HLT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S0;
            halted  <= 1'b0;
        end else if (active) begin
            state_q <= state_t'(state_q + 3'd1);
            if (HALT_STICKY && halt_now) begin
                halted <= 1'b1;
            end
        end
    end

    cpu_ctrl_decode u_decode (
        .state   (state_q),
        .opcode  (opcode),
        .zero    (zero),
        .strobes (strobes)
    );

    // rst_n is folded in so a reset mid-instruction kills any strobe without waiting for a clock
    assign gate = rst_n && active;

    assign load_ir     = gate && strobes[STB_LOAD_IR];
    assign rd          = gate && strobes[STB_RD];
    assign wr          = gate && strobes[STB_WR];
    assign inc_pc      = gate && strobes[STB_INC_PC];
    assign load_pc     = gate && strobes[STB_LOAD_PC];
    assign load_acc    = gate && strobes[STB_LOAD_ACC];
    assign datactl_ena = gate && strobes[STB_DATACTL];
    assign alu_en      = gate && strobes[STB_ALU_EN];
    assign halt        = rst_n && (halted || halt_now);
    assign state       = state_q;

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed self-checking bench for cpu_controller
module tb_cpu_controller;

    localparam logic [2:0] OPC_HLT = 3'd0;
    localparam logic [2:0] OPC_SKZ = 3'd1;
    localparam logic [2:0] OPC_ADD = 3'd2;
    localparam logic [2:0] OPC_AND = 3'd3;
    localparam logic [2:0] OPC_XOR = 3'd4;
    localparam logic [2:0] OPC_LDA = 3'd5;
    localparam logic [2:0] OPC_STO = 3'd6;
    localparam logic [2:0] OPC_JMP = 3'd7;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] opcode;
    logic       zero;
    logic       load_ir;
    logic       rd;
    logic       wr;
    logic       inc_pc;
    logic       load_pc;
    logic       load_acc;
    logic       datactl_ena;
    logic       alu_en;
    logic       halt;
    logic [2:0] state;

    int passed = 0;
    int total  = 0;

    logic [8:0] obs;
    assign obs = {load_ir, rd, wr, inc_pc, load_pc, load_acc, datactl_ena, alu_en, halt};

    cpu_controller #(
        .OP_W        (3),
        .HALT_STICKY (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .opcode      (opcode),
        .zero        (zero),
        .load_ir     (load_ir),
        .rd          (rd),
        .wr          (wr),
        .inc_pc      (inc_pc),
        .load_pc     (load_pc),
        .load_acc    (load_acc),
        .datactl_ena (datactl_ena),
        .alu_en      (alu_en),
        .halt        (halt),
        .state       (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Per-state masks: bit n of each mask is the strobe value in state Sn
    function automatic logic [8:0] pick(input logic [7:0] m_ir, input logic [7:0] m_rd,
                                        input logic [7:0] m_wr, input logic [7:0] m_inc,
                                        input logic [7:0] m_pc, input logic [7:0] m_acc,
                                        input logic [7:0] m_dc, input logic [7:0] m_alu,
                                        input logic [2:0] s);
        return {m_ir[s], m_rd[s], m_wr[s], m_inc[s], m_pc[s], m_acc[s], m_dc[s], m_alu[s], 1'b0};
    endfunction

    task automatic apply_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        en     = 1'b1;
        opcode = OPC_ADD;
        zero   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (state !== 3'd0 || obs !== 9'd0)
            $display("FAIL reset_hold: got state=%0d strobes=%b, want state=0 strobes=%b", state, obs, 9'd0);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || obs !== 9'b110000000)
            $display("FAIL reset_first_fetch: got state=%0d strobes=%b, want state=0 strobes=%b", state, obs, 9'b110000000);
        else
            passed++;
        @(negedge clk);
    endtask

    task automatic test_aluop_back_to_back;
        logic [2:0] ops [4];
        logic [8:0] exp;
        ops = '{OPC_ADD, OPC_AND, OPC_XOR, OPC_LDA};
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            opcode = ops[k];
            zero   = k[0];
            for (int i = 0; i < 8; i++) begin
                #1;
                exp = pick(8'h03, 8'h73, 8'h00, 8'h0A, 8'h00, 8'h40, 8'h00, 8'h20, i[2:0]);
                total++;
                if (state !== i[2:0] || obs !== exp)
                    $display("FAIL aluop op=%0d S%0d: got state=%0d strobes=%b, want strobes=%b", opcode, i, state, obs, exp);
                else
                    passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_sto;
        logic [8:0] exp;
        apply_reset();
        opcode = OPC_STO;
        zero   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp = pick(8'h03, 8'h03, 8'h20, 8'h0A, 8'h00, 8'h00, 8'h70, 8'h00, i[2:0]);
            total++;
            if (state !== i[2:0] || obs !== exp)
                $display("FAIL sto S%0d: got state=%0d strobes=%b, want strobes=%b", i, state, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_skz;
        logic [8:0] exp;
        apply_reset();
        opcode = OPC_SKZ;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            for (int i = 0; i < 8; i++) begin
                #1;
                exp = pick(8'h03, 8'h03, 8'h00, (k == 0) ? 8'hAA : 8'h0A,
                           8'h00, 8'h00, 8'h00, 8'h00, i[2:0]);
                total++;
                if (state !== i[2:0] || obs !== exp)
                    $display("FAIL skz zero=%0b S%0d: got state=%0d strobes=%b, want strobes=%b", zero, i, state, obs, exp);
                else
                    passed++;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_jmp;
        logic [8:0] exp;
        apply_reset();
        opcode = OPC_JMP;
        zero   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp = pick(8'h03, 8'h03, 8'h00, 8'h0A, 8'h30, 8'h00, 8'h00, 8'h00, i[2:0]);
            total++;
            if (state !== i[2:0] || obs !== exp)
                $display("FAIL jmp S%0d: got state=%0d strobes=%b, want strobes=%b", i, state, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_halt;
        logic [8:0] exp;
        apply_reset();
        opcode = OPC_HLT;
        zero   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            exp = pick(8'h03, 8'h03, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, i[2:0]);
            exp[0] = (i == 3);
            total++;
            if (state !== i[2:0] || obs !== exp)
                $display("FAIL halt_seq S%0d: got state=%0d strobes=%b, want strobes=%b", i, state, obs, exp);
            else
                passed++;
            @(negedge clk);
        end
        for (int k = 0; k < 20; k++) begin
            en     = (k % 3) != 0;
            opcode = k[2:0];
            zero   = k[1];
            #1;
            total++;
            if (state !== 3'd4 || obs !== 9'b000000001)
                $display("FAIL halt_park cyc%0d: got state=%0d strobes=%b, want state=4 strobes=%b", k, state, obs, 9'b000000001);
            else
                passed++;
            @(negedge clk);
        end
        opcode = OPC_ADD;
        en     = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 3'd0 || obs !== 9'd0)
            $display("FAIL halt_reset_assert: got state=%0d strobes=%b, want state=0 strobes=%b", state, obs, 9'd0);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || obs !== 9'b110000000)
            $display("FAIL halt_reset_release: got state=%0d strobes=%b, want state=0 strobes=%b", state, obs, 9'b110000000);
        else
            passed++;
        @(negedge clk);
    endtask

    task automatic test_freeze;
        apply_reset();
        opcode = OPC_ADD;
        zero   = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b0;
        #1;
        total++;
        if (state !== 3'd5 || obs !== 9'd0)
            $display("FAIL freeze_enter: got state=%0d strobes=%b, want state=5 strobes=%b", state, obs, 9'd0);
        else
            passed++;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            total++;
            if (state !== 3'd5 || obs !== 9'd0)
                $display("FAIL freeze_hold cyc%0d: got state=%0d strobes=%b, want state=5 strobes=%b", k, state, obs, 9'd0);
            else
                passed++;
        end
        en = 1'b1;
        #1;
        total++;
        if (state !== 3'd5 || obs !== 9'b010000010)
            $display("FAIL freeze_resume: got state=%0d strobes=%b, want state=5 strobes=%b", state, obs, 9'b010000010);
        else
            passed++;
        @(negedge clk);
        #1;
        total++;
        if (state !== 3'd6 || obs !== 9'b010001000)
            $display("FAIL freeze_next: got state=%0d strobes=%b, want state=6 strobes=%b", state, obs, 9'b010001000);
        else
            passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_sto;
        apply_reset();
        opcode = OPC_STO;
        zero   = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (state !== 3'd5 || wr !== 1'b1)
            $display("FAIL sto_mid_wr: got state=%0d wr=%b, want state=5 wr=1", state, wr);
        else
            passed++;
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (state !== 3'd0 || obs !== 9'd0)
            $display("FAIL sto_abort: got state=%0d strobes=%b, want state=0 strobes=%b", state, obs, 9'd0);
        else
            passed++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (state !== 3'd0 || obs !== 9'b110000000)
            $display("FAIL sto_restart: got state=%0d strobes=%b, want state=0 strobes=%b", state, obs, 9'b110000000);
        else
            passed++;
        @(negedge clk);
        #1;
        total++;
        if (state !== 3'd1 || obs !== 9'b110100000)
            $display("FAIL sto_restart_s1: got state=%0d strobes=%b, want state=1 strobes=%b", state, obs, 9'b110100000);
        else
            passed++;
        @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        opcode = OPC_ADD;
        zero   = 1'b0;
        test_reset();
        test_aluop_back_to_back();
        test_sto();
        test_skz();
        test_jmp();
        test_halt();
        test_freeze();
        test_reset_mid_sto();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
